// File: rtl/adc_test_pkg.sv
// rtl/adc_test_pkg.sv - shared types and defaults for the ADC test/playback path
package adc_test_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  localparam int DEF_PRECISION = 10;
  localparam int DEF_ADDR_W    = 10;
  localparam int PIPE_W        = 16;
endpackage

// File: rtl/code_playback_source_if.sv
// rtl/code_playback_source_if.sv - pipe-in word bus and playback code stream
interface code_playback_source_if #(
  parameter int PRECISION = adc_test_pkg::DEF_PRECISION
);
  import adc_test_pkg::*;

  logic                 pipe_write;
  logic [PIPE_W-1:0]    pipe_data;
  logic [PRECISION-1:0] code_out;
  logic                 code_valid;

  modport master (output pipe_write, pipe_data, input code_out, code_valid);
  modport slave  (input pipe_write, pipe_data, output code_out, code_valid);
endinterface

// File: rtl/code_playback_source_code_ram.sv
// rtl/code_playback_source_code_ram.sv - simple dual-port RAM, one-cycle registered read
module code_ram #(
  parameter int WIDTH  = 10,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/code_playback_source.sv
// rtl/code_playback_source.sv - host-loaded code buffer replayed as a code/strobe stream
module code_playback_source import adc_test_pkg::*; #(
  parameter int PRECISION = DEF_PRECISION,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  code_playback_source_if.slave bus,
  input  logic                  clear,
  input  logic                  play_start,
  input  logic                  play_stop,
  input  logic                  loop_en,
  input  logic [15:0]           rate_div,
  output logic                  playing,
  output logic                  done,
  output logic [ADDR_W:0]       buf_count,
  output logic                  err
);
  state_t               state, next_state;
  logic [ADDR_W-1:0]    rd_addr, addr_1, addr_2, raddr;
  logic [PRECISION-1:0] rdata, code_q;
  logic [15:0]          hold;
  logic                 valid_q, wr_en, step, more, abort, unused_bits;

  function automatic logic [ADDR_W-1:0] succ(input logic [ADDR_W-1:0] a,
                                             input logic [ADDR_W:0]   count);
    return (({1'b0, a} + (ADDR_W+1)'(1)) < count) ? a + ADDR_W'(1) : '0;
  endfunction

  // rd_addr is the address shown on code_out; the RAM always holds the one after it
  assign addr_1      = succ(rd_addr, buf_count);
  assign addr_2      = succ(addr_1, buf_count);
  assign step        = (state == PLAY) && (hold == '0);
  assign more        = (({1'b0, rd_addr} + (ADDR_W+1)'(1)) < buf_count) || loop_en;
  assign abort       = clear || (play_stop && (state != IDLE));
  assign unused_bits = ^bus.pipe_data[PIPE_W-1:PRECISION];

  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;

  code_ram #(.WIDTH(PRECISION), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (buf_count[ADDR_W-1:0]),
    .wr_data (bus.pipe_data[PRECISION-1:0]),
    .rd_addr (raddr),
    .rd_data (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) next_state = IDLE;
    else begin
      case (state)
        IDLE:    if (play_start && (buf_count != '0)) next_state = PRIME;
        PRIME:   next_state = PLAY;
        PLAY:    if (step && !more) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    playing = (state != IDLE);
    wr_en   = bus.pipe_write && !clear && (state == IDLE) && !buf_count[ADDR_W];
    raddr   = '0;
    case (state)
      PRIME:   raddr = addr_1;
      PLAY:    raddr = step ? addr_2 : addr_1;
      default: raddr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      done      <= 1'b0;
      buf_count <= '0;
      err       <= 1'b0;
      rd_addr   <= '0;
      hold      <= '0;
    end else begin
      valid_q <= 1'b0;
      done    <= 1'b0;
      if (clear) begin
        buf_count <= '0;
        err       <= 1'b0;
        done      <= playing;
      end else begin
        if (wr_en) buf_count <= buf_count + (ADDR_W+1)'(1);
        if (bus.pipe_write && !wr_en) err <= 1'b1;
        if ((state == IDLE) && play_start && (buf_count == '0)) err <= 1'b1;
        if (abort) done <= 1'b1;
        else begin
          case (state)
            IDLE: rd_addr <= '0;
            PRIME: begin
              code_q  <= rdata;
              valid_q <= 1'b1;
              hold    <= rate_div;
            end
            PLAY: begin
              if (hold != '0) hold <= hold - 16'd1;
              else if (more) begin
                code_q  <= rdata;
                valid_q <= 1'b1;
                rd_addr <= addr_1;
                hold    <= rate_div;
              end else done <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_code_playback_source.sv
// tb/tb_code_playback_source.sv - randomized bench for code_playback_source against a sequence model
module tb_code_playback_source;
  logic        clk = 1'b0;
  logic        rst, clear, play_start, play_stop, loop_en;
  logic [15:0] rate_div;
  logic        playing, done, err;
  logic [10:0] buf_count;

  int n_vec = 0;
  int n_err = 0;
  int ref_mem [1024];
  int ref_count, ref_code, ref_err;
  int fixed_words [4] = '{32'h0003, 32'hFC01, 32'h03FF, 32'h0200};

  code_playback_source_if #(.PRECISION(10)) bus ();

  code_playback_source #(.PRECISION(10), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clear      (clear),
    .play_start (play_start),
    .play_stop  (play_stop),
    .loop_en    (loop_en),
    .rate_div   (rate_div),
    .playing    (playing),
    .done       (done),
    .buf_count  (buf_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "/buf_count"}, 32'(buf_count), 32'(ref_count));
    check({tag, "/err"}, 32'(err), 32'(ref_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/code_out"}, 32'(bus.code_out), 0);
    check({tag, "/code_valid"}, 32'(bus.code_valid), 0);
    check({tag, "/playing"}, 32'(playing), 0);
    check({tag, "/done"}, 32'(done), 0);
    check({tag, "/buf_count"}, 32'(buf_count), 0);
    check({tag, "/err"}, 32'(err), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    ref_count = 0; ref_err = 0; ref_code = 0;
  endtask

  // mode 0: fixed table, 1: random words, 2: ramp with random junk in the upper bits
  task automatic load(input int n, input int mode);
    int w;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       w = fixed_words[i];
        1:       w = int'($urandom_range(0, 65535));
        default: w = (int'($urandom_range(0, 63)) << 10) | (i % 1024);
      endcase
      bus.pipe_write = 1'b1;
      bus.pipe_data  = w[15:0];
      @(negedge clk);
      if (ref_count < 1024) begin
        ref_mem[ref_count] = w % 1024;
        ref_count++;
      end else ref_err = 1;
    end
    bus.pipe_write = 1'b0;
  endtask

  task automatic clear_buf(input bit with_write);
    clear = 1'b1;
    bus.pipe_write = with_write;
    bus.pipe_data  = 16'h0155;
    @(negedge clk);
    clear = 1'b0;
    bus.pipe_write = 1'b0;
    ref_count = 0; ref_err = 0;
    check("clear/done", 32'(done), 0);
    check_status("clear");
  endtask

  // Step k counts observations after play_start is sampled; strobes fall on 2 + i*(rd+1).
  task automatic play_run(input int rd, input bit lp, input int stop_t, input bit by_clear, input int inj_t);
    int n, period, end_t, idx;
    bit exp_v;
    n = ref_count;
    period = rd + 1;
    end_t = (stop_t > 0) ? stop_t : 2 + n * period;
    rate_div = rd[15:0];
    loop_en = lp;
    play_start = 1'b1;
    for (int k = 1; k <= end_t + 2; k++) begin
      @(negedge clk);
      play_start = 1'b0; play_stop = 1'b0; clear = 1'b0; bus.pipe_write = 1'b0;
      exp_v = 1'b0;
      if (k >= 2 && k < end_t && ((k - 2) % period) == 0) begin
        idx = (k - 2) / period;
        if (lp || idx < n) begin
          exp_v = 1'b1;
          ref_code = ref_mem[idx % n];
        end
      end
      check("play/code_valid", 32'(bus.code_valid), 32'(exp_v));
      check("play/code_out", 32'(bus.code_out), 32'(ref_code));
      check("play/done", 32'(done), 32'(k == end_t));
      check("play/playing", 32'(playing), 32'(k < end_t));
      if (k + 1 == stop_t) begin
        if (by_clear) clear = 1'b1;
        else play_stop = 1'b1;
      end
      if (k + 1 == inj_t) begin
        bus.pipe_write = 1'b1;
        bus.pipe_data  = 16'($urandom);
      end
    end
    play_start = 1'b0; play_stop = 1'b0; clear = 1'b0; bus.pipe_write = 1'b0;
    if (inj_t > 0) ref_err = 1;
    if (by_clear && stop_t > 0) begin
      ref_count = 0; ref_err = 0;
    end
  endtask

  task automatic empty_start();
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    ref_err = 1;
    for (int i = 0; i < 4; i++) begin
      check("empty/code_valid", 32'(bus.code_valid), 0);
      check("empty/playing", 32'(playing), 0);
      @(negedge clk);
    end
    check_status("empty");
  endtask

  task automatic mid_rst();
    rate_div = 16'd1;
    loop_en = 1'b1;
    play_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      play_start = 1'b0;
    end
    check("midrst/playing_before", 32'(playing), 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    ref_count = 0; ref_err = 0; ref_code = 0;
    empty_start();
  endtask

  initial begin
    int n, rd, nat, st, end_t, inj;
    bit lp, bc;
    rst = 1'b1; clear = 1'b0; play_start = 1'b0; play_stop = 1'b0;
    loop_en = 1'b0; rate_div = '0;
    bus.pipe_write = 1'b0; bus.pipe_data = '0;
    ref_code = 0;
    @(negedge clk);
    do_reset();

    load(4, 0);
    check_status("load4");
    play_run(2, 1'b0, 0, 1'b0, 0);
    check_status("oneshot");
    play_run(0, 1'b1, 13, 1'b0, 0);
    check_status("loopstop");
    play_run(1, 1'b0, 0, 1'b0, 5);
    check_status("inject");

    for (int it = 0; it < 8; it++) begin
      clear_buf(1'b0);
      n = int'($urandom_range(1, 12));
      load(n, 1);
      check_status("rand_load");
      rd  = int'($urandom_range(0, 3));
      lp  = 1'($urandom_range(0, 1));
      nat = 2 + n * (rd + 1);
      if (lp) st = int'($urandom_range(2, 40));
      else    st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, nat)) : 0;
      end_t = (st > 0) ? st : nat;
      bc  = (st > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      inj = ($urandom_range(0, 2) == 0 && end_t > 2) ? int'($urandom_range(2, end_t - 1)) : 0;
      play_run(rd, lp, st, bc, inj);
      check_status("rand_play");
    end

    clear_buf(1'b0);
    load(1025, 2);
    check_status("fill");
    play_run(0, 1'b0, 0, 1'b0, 0);
    check_status("ramp");
    clear_buf(1'b1);

    empty_start();

    clear_buf(1'b0);
    load(3, 1);
    mid_rst();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/code_playback_source.md
Name: code_playback_source

Overview:
- Host-to-hardware counterpart of the ADC capture path. The host streams 16-bit words in through a FrontPanel pipe-in endpoint, and the block stores the low PRECISION bits of each word as ADC codes in an internal buffer.
- On command, the block replays the stored codes at a programmable rate as a code/strobe stream. That stream drives the ADC-code input of the capture path (loopback self-test) or an external DAC.
- Sits on ti_clk, next to the okPipeIn and okTriggerIn endpoints.

Parameters:
- PRECISION, 10, code width in bits (matches capture path).
- ADDR_W, 10, buffer address width; depth = 2**ADDR_W words.

Ports:
- clk  in  1  ti_clk domain clock.
- rst  in  1  synchronous active-high reset.
- pipe_write  in  1  ep_write strobe from okPipeIn; one word per high cycle.
- pipe_data  in  16  ep_dataout from okPipeIn; bits [PRECISION-1:0] used, upper bits ignored.
- clear  in  1  one-cycle pulse (trigger-in); empties the buffer.
- play_start  in  1  one-cycle pulse (trigger-in); begins playback.
- play_stop  in  1  one-cycle pulse (trigger-in); aborts playback.
- loop_en  in  1  wire-in; 1 = wrap to address 0 after the last code, 0 = one-shot.
- rate_div  in  16  wire-in; each code is held rate_div+1 clk cycles.
- code_out  out  PRECISION  current playback code.
- code_valid  out  1  one-cycle strobe when code_out takes a new value.
- playing  out  1  high in PRIME/PLAY.
- done  out  1  one-cycle pulse at one-shot completion or stop.
- buf_count  out  ADDR_W+1  number of stored codes.
- err  out  1  sticky: write dropped (full or not IDLE), or start with empty buffer; cleared by clear or rst.

Behaviour:
- Reset: state IDLE; code_out=0, code_valid=0, playing=0, done=0, buf_count=0, err=0; read address and hold counter = 0. Buffer contents are not cleared.
- Load (IDLE only):
  - pipe_write with buf_count < 2**ADDR_W writes pipe_data[PRECISION-1:0] to address buf_count; buf_count increments the next cycle.
  - pipe_write at buf_count = 2**ADDR_W: word dropped, err set.
  - pipe_write in PRIME/PLAY: word dropped, err set, buffer unchanged.
- clear: in any state, buf_count=0, err=0, state IDLE; done pulses if the block was playing. A pipe_write in the same cycle as clear is dropped, and err is not set.
- States:
  - IDLE: play_start with buf_count>0 goes to PRIME (rd_addr=0, RAM read issued). play_start with buf_count=0 sets err and stays IDLE.
  - PRIME: one cycle covering RAM read latency. Goes to PLAY; RAM data is loaded into code_out on entry to PLAY.
  - PLAY: on entry, code_out = mem[rd_addr], code_valid=1, hold counter=rate_div. The counter decrements each cycle. At 0:
    - if rd_addr+1 < buf_count: next read issued, and code_out updates exactly rate_div+1 cycles after the previous update;
    - else if loop_en: rd_addr wraps to 0, continuous cadence, no gap cycle;
    - else: done pulses, go to IDLE; code_out holds its last value.
- Cadence: the next read is prefetched one cycle before the counter expires, so code_valid strobes are exactly rate_div+1 cycles apart. With rate_div=0, a strobe fires every cycle.
- Control priority:
  - play_stop in PRIME/PLAY: go to IDLE next cycle, done pulses, code_out holds its value. play_stop in IDLE has no effect.
  - Priority in the same cycle: rst > clear > play_stop > play_start. play_start while playing is ignored (no restart, no err).
- rate_div and loop_en are sampled live. A change takes effect at the next counter reload or wrap decision.
- latency: play_start to first code_valid = 2 cycles (start cycle → PRIME → PLAY).
- buf_count is the loaded length. Playback never reads addresses ≥ buf_count.

Decomposition:
- Shared package (adc_test_pkg):
  - state enum {IDLE, PRIME, PLAY};
  - default PRECISION/ADDR_W constants;
  - pipe word width constant 16.
- Sub-module code_ram: simple dual-port synchronous RAM, 1 write port, 1 read port, 1-cycle registered read, width PRECISION, depth 2**ADDR_W. It must infer block RAM.
- Top: load logic, FSM, hold counter, output registers.

Test Plan:
- Load 4 words 0x0003, 0xFC01, 0x03FF, 0x0200; rate_div=2; loop_en=0; play_start → codes 0x003, 0x001, 0x3FF, 0x200 with code_valid 3 cycles apart; first strobe 2 cycles after start; done pulses once; buf_count=4; err=0.
- Same buffer, loop_en=1, rate_div=0 → codes strobe every cycle, sequence 3,1,3FF,200,3,1,… with no gap at the wrap; play_stop → playing=0 next cycle, done pulses, code_out held.
- Fill 1024 words, then 1 more pipe_write → buf_count=1024, err=1; clear → buf_count=0, err=0.
- play_start with empty buffer → err=1, playing stays 0, no code_valid.
- pipe_write during PLAY → err=1, buf_count unchanged, playback sequence unaffected; rst mid-PLAY → all outputs 0 next cycle; after rst, play_start replays the old RAM contents only if buf_count is reloaded (buf_count=0 → err).
- Loopback: drive the capture path's code input from code_out, clocked on code_valid, with ramp 0..1023 → host pipe-out readback equals the ramp.
